replica_error_detector: RTL and testbench
=========================================

REPLICA_ERROR_DETECTOR -- requirements
Module: replica_error_detector

Interface
REQ-001 Parameters: INVERT, 0, 1 = chain has odd inverter count (expected output = ~launch); ERR_CNT_W, 16, error counter width; THRESH, 4, consecutive mismatches that raise alarm (1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 enable  input  1  level; 1 = run launch/check cycles.
REQ-005 replica_in  output  1  launch bit driven into the replica delay chain.
REQ-006 replica_out  input  1  chain output returning to the detector.
REQ-007 alarm_ack  input  1  pulse; clears alarm.
REQ-008 clear_cnt  input  1  pulse; zeroes err_count.
REQ-009 err_pulse  output  1  one-cycle pulse per detected mismatch.
REQ-010 alarm  output  1  level; THRESH consecutive mismatches seen.
REQ-011 err_count  output  ERR_CNT_W  total mismatches, saturating.
REQ-012 stuck_fault  output  1  level; mismatch persisted through shadow sample (see Configuration).

Function
REQ-013 FSM states IDLE, LAUNCH, CHECK, SHADOW, ALARM; the block SHALL hold one state per cycle.
REQ-014 IDLE: enable=1 -> LAUNCH; else stay.
REQ-015 LAUNCH: replica_in SHALL toggle on the leaving edge; -> CHECK.
REQ-016 CHECK: replica_out SHALL be sampled exactly one cycle after the toggle; expected = replica_in XOR INVERT.
REQ-017 CHECK match: consecutive count <= 0; -> LAUNCH if enable else IDLE.
REQ-018 CHECK mismatch: err_pulse=1 next cycle; err_count +1 saturating at all-ones; consecutive count +1; -> SHADOW (macro on) or as REQ-020 (macro off).
REQ-019 SHADOW: replica_out resampled one cycle later; still mismatched -> stuck_fault <= 1; matched -> timing-late error, stuck_fault unchanged; then REQ-020.
REQ-020 After mismatch handling: consecutive count == THRESH -> ALARM; else LAUNCH if enable else IDLE.
REQ-021 ALARM: alarm=1, replica_in held, no launches; alarm_ack=1 -> alarm<=0, consecutive count<=0, -> IDLE.
REQ-022 enable deasserted in CHECK/SHADOW SHALL NOT abort the check in progress.
REQ-023 alarm_ack outside ALARM SHALL be ignored.
REQ-024 clear_cnt coincident with an increment: clear wins, err_count=0.
REQ-025 stuck_fault SHALL clear only on rst or alarm_ack.
REQ-026 Replica delay must be less than one clk period minus setup; any longer delay SHALL register as a mismatch.

Reset
REQ-027 rst=1 SHALL force IDLE, replica_in=0, err_pulse=0, alarm=0, err_count=0, stuck_fault=0, consecutive count=0; rst overrides all inputs, including mid-check and in ALARM.

Configuration
REQ-028 Macro REPLICA_DET_SHADOW_EN defined: SHADOW state and stuck_fault classification present.
REQ-029 Undefined: SHADOW unreachable/omitted, CHECK mismatch goes straight to REQ-020, stuck_fault tied 0.

Structure
REQ-030 Shared package replica_det_pkg SHALL hold the FSM state enum and the default ERR_CNT_W/THRESH constants.
REQ-031 One sub-module, replica_err_counter (saturating counter with clear priority), SHALL implement err_count.
REQ-032 The replica chain SHALL stay outside this block; connect via replica_in/replica_out only.

Verification
REQ-033 Ideal loopback (replica_out = replica_in, INVERT=0), enable=1 for 40 cycles -> replica_in toggles every 2 cycles, err_count=0, alarm=0.
REQ-034 replica_out driven late by 1 cycle for 3 checks -> 3 err_pulses, err_count=3, alarm=0, stuck_fault=0.
REQ-035 replica_out stuck 0, THRESH=4 -> alarm=1 after 4th mismatch, stuck_fault=1 (macro on) / 0 (macro off); alarm_ack -> alarm=0, state IDLE.
REQ-036 ERR_CNT_W=4, 20 mismatches with repeated alarm_ack -> err_count saturates at 15; clear_cnt with coincident mismatch -> 0.
REQ-037 rst asserted in CHECK and in ALARM -> all outputs 0 next cycle, IDLE.

Source files
------------

// File: rtl/replica_det_pkg.sv
// Shared definitions for the replica-path error detector: FSM state
// encoding, default sizing constants and the expected-output helper.
package replica_det_pkg;

  localparam int unsigned ERR_CNT_W_DEF = 16;
  localparam int unsigned THRESH_DEF    = 4;
  // Wide enough for the largest legal threshold (15).
  localparam int unsigned CONSEC_W      = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_CHECK  = 3'd2,
    S_SHADOW = 3'd3,
    S_ALARM  = 3'd4
  } det_state_e;

  // Value the chain output must show for a given launch bit.
  function automatic logic expected_out(input logic launch, input logic inv);
    return launch ^ inv;
  endfunction

endpackage

// File: rtl/replica_err_counter.sv
// Saturating mismatch counter. A clear request takes priority over an
// increment arriving in the same cycle.
module replica_err_counter
  import replica_det_pkg::*;
#(
  parameter int unsigned W = ERR_CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear first, otherwise increment until all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/replica_error_detector.sv
// Replica-path timing error detector. Each launch toggles replica_in into
// an external delay chain; one cycle later replica_out is compared with the
// expected value. Mismatches pulse err_pulse, bump a saturating counter and
// a consecutive-miss run; a run of THRESH misses parks the block in ALARM
// until alarm_ack.
// Optional build macro REPLICA_DET_SHADOW_EN adds a SHADOW re-sample after
// each mismatch that separates late arrivals from stuck chains (stuck_fault).
// Without it, stuck_fault is tied low and SHADOW is never entered.
// dbg_state_o exposes the FSM state for checkers.
module replica_error_detector
  import replica_det_pkg::*;
#(
  parameter bit          INVERT    = 1'b0,
  parameter int unsigned ERR_CNT_W = ERR_CNT_W_DEF,
  parameter int unsigned THRESH    = THRESH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 replica_in,
  input  logic                 replica_out,
  input  logic                 alarm_ack,
  input  logic                 clear_cnt,
  output logic                 err_pulse,
  output logic                 alarm,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 stuck_fault,
  output det_state_e           dbg_state_o
);

  localparam logic [CONSEC_W-1:0] THRESH_C = CONSEC_W'(THRESH);

  det_state_e          state_q, state_d;
  logic                launch_q, launch_d;
  logic                pulse_q, pulse_d;
  logic [CONSEC_W-1:0] consec_q, consec_d;
  logic                cnt_inc;
  logic                mismatch;
`ifdef REPLICA_DET_SHADOW_EN
  logic                stuck_q, stuck_d;
`endif

  // Chain output disagrees with what the current launch bit should produce.
  assign mismatch = replica_out != expected_out(launch_q, INVERT);

  // Where to go once a mismatch has been accounted for.
  function automatic det_state_e after_error(input logic [CONSEC_W-1:0] run,
                                             input logic en);
    if (run == THRESH_C) return S_ALARM;
    return en ? S_LAUNCH : S_IDLE;
  endfunction

  // Next-state and datapath control; enable is only consulted at the end of
  // a check so dropping it mid-check never aborts the comparison.
  always_comb begin
    state_d  = state_q;
    launch_d = launch_q;
    pulse_d  = 1'b0;
    consec_d = consec_q;
    cnt_inc  = 1'b0;
`ifdef REPLICA_DET_SHADOW_EN
    stuck_d  = stuck_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        launch_d = ~launch_q;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          pulse_d  = 1'b1;
          cnt_inc  = 1'b1;
          consec_d = consec_q + 1'b1;
`ifdef REPLICA_DET_SHADOW_EN
          state_d  = S_SHADOW;
`else
          state_d  = after_error(consec_d, enable);
`endif
        end else begin
          consec_d = '0;
          state_d  = enable ? S_LAUNCH : S_IDLE;
        end
      end
`ifdef REPLICA_DET_SHADOW_EN
      S_SHADOW: begin
        // Still wrong a cycle later: the chain is stuck, not just slow.
        if (mismatch) stuck_d = 1'b1;
        state_d = after_error(consec_q, enable);
      end
`endif
      S_ALARM: begin
        // Launch bit is held; only an acknowledge leaves this state.
        if (alarm_ack) begin
          consec_d = '0;
`ifdef REPLICA_DET_SHADOW_EN
          stuck_d  = 1'b0;
`endif
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      launch_q <= 1'b0;
      pulse_q  <= 1'b0;
      consec_q <= '0;
`ifdef REPLICA_DET_SHADOW_EN
      stuck_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
      pulse_q  <= pulse_d;
      consec_q <= consec_d;
`ifdef REPLICA_DET_SHADOW_EN
      stuck_q  <= stuck_d;
`endif
    end
  end

  replica_err_counter #(
    .W(ERR_CNT_W)
  ) u_err_counter (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (cnt_inc),
    .clr_i  (clear_cnt),
    .count_o(err_count)
  );

  assign replica_in  = launch_q;
  assign err_pulse   = pulse_q;
  assign alarm       = (state_q == S_ALARM);
  assign dbg_state_o = state_q;
`ifdef REPLICA_DET_SHADOW_EN
  assign stuck_fault = stuck_q;
`else
  assign stuck_fault = 1'b0;
`endif

endmodule

// File: tb/tb_replica_error_detector.sv
// Bench for replica_error_detector: directed scenarios plus a randomized
// phase, all checked every cycle against a transaction-level model.
module tb_replica_error_detector;
  import replica_det_pkg::*;

  localparam bit INV     = 1'b0;
  localparam int W       = 4;
  localparam int TH      = 4;
  localparam int CNT_MAX = (1 << W) - 1;
`ifdef REPLICA_DET_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  // Chain behaviours driven onto replica_out.
  localparam int M_IDEAL = 0;
  localparam int M_LATE  = 1;
  localparam int M_ST0   = 2;
  localparam int M_ST1   = 3;
  localparam int M_POL   = 4;
  localparam int M_RND   = 5;

  // Model phases.
  localparam int P_IDLE = 0, P_LAUNCH = 1, P_CHECK = 2, P_SHADOW = 3, P_ALARM = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         alarm_ack = 1'b0;
  logic         clear_cnt = 1'b0;
  logic         replica_in;
  logic         replica_out;
  logic         err_pulse;
  logic         alarm;
  logic [W-1:0] err_count;
  logic         stuck_fault;
  det_state_e   dbg_state;

  int   mode = M_IDEAL;
  logic rnd_bit = 1'b0;
  logic late_q = 1'b0;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  replica_error_detector #(
    .INVERT   (INV),
    .ERR_CNT_W(W),
    .THRESH   (TH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .replica_in (replica_in),
    .replica_out(replica_out),
    .alarm_ack  (alarm_ack),
    .clear_cnt  (clear_cnt),
    .err_pulse  (err_pulse),
    .alarm      (alarm),
    .err_count  (err_count),
    .stuck_fault(stuck_fault),
    .dbg_state_o(dbg_state)
  );

  // ---------------- external replica chain ----------------
  always @(posedge clk) late_q <= replica_in;

  always_comb begin
    replica_out = replica_in ^ INV;
    case (mode)
      M_LATE:  replica_out = late_q ^ INV;
      M_ST0:   replica_out = 1'b0;
      M_ST1:   replica_out = 1'b1;
      M_POL:   replica_out = ~(replica_in ^ INV);
      M_RND:   replica_out = rnd_bit;
      default: replica_out = replica_in ^ INV;
    endcase
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Inputs are snapshotted mid-low-phase, after the drivers have settled,
  // and consumed at the following rising edge.
  logic s_rst = 1'b1, s_en = 1'b0, s_ro = 1'b0, s_ack = 1'b0, s_clr = 1'b0;
  always @(negedge clk) begin
    #2;
    s_rst = rst; s_en = enable; s_ro = replica_out; s_ack = alarm_ack; s_clr = clear_cnt;
  end

  int   m_phase = P_IDLE;
  logic m_rin = 1'b0, m_pulse = 1'b0, m_stuck = 1'b0, m_valid = 1'b0;
  int   m_cnt = 0, m_run = 0;

  function automatic int next_after_miss(input int run, input logic en);
    if (run == TH) return P_ALARM;
    return en ? P_LAUNCH : P_IDLE;
  endfunction

  always @(posedge clk) begin
    logic bad;
    bad = (s_ro !== (m_rin ^ INV));
    if (s_rst) begin
      m_phase = P_IDLE; m_rin = 1'b0; m_pulse = 1'b0; m_stuck = 1'b0;
      m_cnt = 0; m_run = 0; m_valid = 1'b1;
    end else begin
      m_pulse = 1'b0;
      case (m_phase)
        P_IDLE:   if (s_en) m_phase = P_LAUNCH;
        P_LAUNCH: begin m_rin = ~m_rin; m_phase = P_CHECK; end
        P_CHECK: begin
          if (bad) begin
            m_pulse = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
            m_run++;
            m_phase = SHADOW ? P_SHADOW : next_after_miss(m_run, s_en);
          end else begin
            m_run = 0;
            m_phase = s_en ? P_LAUNCH : P_IDLE;
          end
        end
        P_SHADOW: begin
          if (bad) m_stuck = 1'b1;
          m_phase = next_after_miss(m_run, s_en);
        end
        default: if (s_ack) begin m_run = 0; m_stuck = 1'b0; m_phase = P_IDLE; end
      endcase
      if (s_clr) m_cnt = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("replica_in", 32'(replica_in), 32'(m_rin));
      check("err_pulse", 32'(err_pulse), 32'(m_pulse));
      check("alarm", 32'(alarm), 32'(m_phase == P_ALARM));
      check("err_count", 32'(err_count), 32'(m_cnt));
      check("stuck_fault", 32'(stuck_fault), 32'(m_stuck));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Walk until the FSM reports st, acknowledging alarms on the way unless
  // ALARM itself is the target.
  task automatic goto_state(input det_state_e st, input int budget, input string name);
    int n = 0;
    while (dbg_state != st && n < budget) begin
      alarm_ack = (st != S_ALARM) && alarm;
      @(negedge clk);
      n++;
    end
    alarm_ack = 1'b0;
    if (dbg_state != st) check(name, 32'(dbg_state), 32'(st));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rin"}, 32'(replica_in), 0);
    check({tag, "_pulse"}, 32'(err_pulse), 0);
    check({tag, "_alarm"}, 32'(alarm), 0);
    check({tag, "_count"}, 32'(err_count), 0);
    check({tag, "_stuck"}, 32'(stuck_fault), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   toggles, pulses, extra, n;
    logic prev, held;

    do_reset();
    check_all_zero("reset");

    // Ideal loopback: toggle every two cycles, no errors.
    mode = M_IDEAL; enable = 1'b1;
    prev = replica_in; toggles = 0;
    repeat (40) begin
      @(negedge clk);
      if (replica_in !== prev) toggles++;
      prev = replica_in;
    end
    check("loop_toggles", toggles, 20);
    check("loop_count", 32'(err_count), 0);
    check("loop_alarm", 32'(alarm), 0);

    // Late chain for three checks, then healthy again.
    do_reset();
    mode = M_LATE; enable = 1'b1; pulses = 0; n = 0;
    while (pulses < 3 && n < 100) begin
      @(negedge clk); n++;
      if (err_pulse) pulses++;
    end
    mode = M_IDEAL; extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (err_pulse) extra++;
    end
    check("late_pulses", pulses + extra, 3);
    check("late_count", 32'(err_count), 3);
    check("late_alarm", 32'(alarm), 0);
    check("late_stuck", 32'(stuck_fault), 0);

    // Persistently wrong chain: alarm after TH consecutive misses.
    do_reset();
    mode = M_POL; enable = 1'b1; pulses = 0; n = 0;
    while (!alarm && n < 100) begin
      @(negedge clk); n++;
      if (err_pulse) pulses++;
    end
    check("alarm_raised", 32'(alarm), 1);
    check("alarm_pulses", pulses, TH);
    check("alarm_count", 32'(err_count), TH);
    check("alarm_stuck", 32'(stuck_fault), 32'(SHADOW));
    held = replica_in;
    repeat (5) @(negedge clk);
    check("alarm_hold_rin", 32'(replica_in), 32'(held));
    check("alarm_hold", 32'(alarm), 1);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    check("ack_alarm", 32'(alarm), 0);
    check("ack_state", 32'(dbg_state), 32'(S_IDLE));
    check("ack_stuck", 32'(stuck_fault), 0);

    // Keep missing through repeated acknowledges until the counter saturates.
    pulses = TH; n = 0;
    while (pulses < 20 && n < 400) begin
      alarm_ack = alarm;
      @(negedge clk); n++;
      if (err_pulse) pulses++;
    end
    alarm_ack = 1'b0;
    check("sat_pulses", pulses, 20);
    check("sat_count", 32'(err_count), CNT_MAX);

    // Clear landing on the same edge as a mismatch increment.
    goto_state(S_CHECK, 60, "reach_check");
    clear_cnt = 1'b1;
    @(negedge clk);
    clear_cnt = 1'b0;
    check("clear_wins", 32'(err_count), 0);
    check("clear_pulse", 32'(err_pulse), 1);

    // Reset in the middle of a check.
    goto_state(S_CHECK, 60, "reach_check2");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_check");

    // Reset while alarmed.
    mode = M_POL; enable = 1'b1;
    goto_state(S_ALARM, 100, "reach_alarm");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_alarm");

    // Randomized traffic against the model.
    repeat (800) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 99) == 0);
      enable    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) mode = $urandom_range(0, 5);
      rnd_bit   = 1'($urandom_range(0, 1));
      alarm_ack = ($urandom_range(0, 5) == 0);
      clear_cnt = ($urandom_range(0, 29) == 0);
    end
    @(negedge clk);
    rst = 1'b0; enable = 1'b0; alarm_ack = 1'b0; clear_cnt = 1'b0; mode = M_IDEAL;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
